// File: rtl/gascon_pkg.sv
// Shared types and constants for the Gascon permutation round sequencer.
package gascon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } seq_state_t;

    localparam int GASCON_MAX_ROUNDS = 12;
    localparam int GASCON_CWIDTH     = 320;

endpackage

// File: rtl/gascon_perm_sequencer.sv
// Drives an external single-round Gascon core one round at a time and chains its output back.
// Optional per-round watchdog enabled by defining GASCON_SEQ_WATCHDOG_EN.
module gascon_perm_sequencer
    import gascon_pkg::*;
#(
    parameter int CWIDTH     = GASCON_CWIDTH,
    parameter int RWIDTH     = 16,
    parameter int MAX_ROUNDS = GASCON_MAX_ROUNDS,
    parameter int WDT_LIMIT  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        nrounds,
    input  logic [CWIDTH-1:0] state_in,
    output logic              ready,
    output logic              busy,
    output logic [CWIDTH-1:0] state_out,
    output logic              valid,
    output logic              error,
    output logic [CWIDTH-1:0] core_c,
    output logic [RWIDTH-1:0] core_round,
    output logic              core_reset,
    input  logic [CWIDTH-1:0] core_cout,
    input  logic              core_done
);

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [CWIDTH-1:0] st_reg;
    logic [3:0]        ridx;
    logic [3:0]        rem;
    logic [3:0]        clamped;
    logic              wdt_expired;

    assign clamped = (nrounds > MAX_R) ? MAX_R : nrounds;

`ifdef GASCON_SEQ_WATCHDOG_EN
    localparam logic [9:0] WDT_MAX = 10'(WDT_LIMIT);

    logic [9:0] wdt;

    // Counter is held at zero outside RUN, so every RUN entry starts a fresh budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt <= '0;
        end else if (state == RUN) begin
            wdt <= wdt + 10'd1;
        end else begin
            wdt <= '0;
        end
    end

    assign wdt_expired = (state == RUN) && !core_done && (wdt == WDT_MAX);
`else
    assign wdt_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (clamped == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_next = (rem == 4'd1) ? DONE : GAP;
                end else if (wdt_expired) begin
                    state_next = IDLE;
                end
            end
            GAP:     state_next = RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == IDLE);
        busy       = (state != IDLE);
        valid      = (state == DONE);
        core_reset = (state != RUN);
        error      = wdt_expired;
        core_c     = st_reg;
        core_round = {{(RWIDTH-4){1'b0}}, ridx};
    end

    // state_out is loaded on the edge into DONE so it is already final while valid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_reg    <= '0;
            ridx      <= '0;
            rem       <= '0;
            state_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        st_reg <= state_in;
                        rem    <= clamped;
                        ridx   <= MAX_R - clamped;
                        if (clamped == 4'd0) begin
                            state_out <= state_in;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        st_reg <= core_cout;
                        ridx   <= ridx + 4'd1;
                        rem    <= rem - 4'd1;
                        if (rem == 4'd1) begin
                            state_out <= core_cout;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gascon_perm_sequencer.sv
// Bench for gascon_perm_sequencer with a behavioural round core (latency 3, XOR of replicated round index).
module tb_gascon_perm_sequencer;

    localparam int CW = 320;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    nrounds;
    logic [CW-1:0] state_in;
    logic          ready;
    logic          busy;
    logic [CW-1:0] state_out;
    logic          valid;
    logic          error;
    logic [CW-1:0] core_c;
    logic [15:0]   core_round;
    logic          core_reset;
    logic [CW-1:0] core_cout;
    logic          core_done;

    logic [1:0]    lat_cnt;
    logic          stuck;
    logic          done_force;

    int n_checks = 0;
    int n_fail   = 0;
    int err_total = 0;

    always #5 clk = ~clk;

    gascon_perm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .nrounds    (nrounds),
        .state_in   (state_in),
        .ready      (ready),
        .busy       (busy),
        .state_out  (state_out),
        .valid      (valid),
        .error      (error),
        .core_c     (core_c),
        .core_round (core_round),
        .core_reset (core_reset),
        .core_cout  (core_cout),
        .core_done  (core_done)
    );

    // Behavioural round core: done on the 4th cycle out of reset, i.e. L = 3.
    always @(posedge clk) begin
        if (core_reset) lat_cnt <= 2'd0;
        else if (lat_cnt != 2'd3) lat_cnt <= lat_cnt + 2'd1;
    end
    assign core_done = done_force | (!stuck && !core_reset && lat_cnt == 2'd3);
    assign core_cout = core_c ^ {20{core_round}};

    always @(negedge clk) if (error) err_total++;

    typedef struct {
        logic [3:0]    nr;
        logic [CW-1:0] sin;
        int            exp_cycle;
        int            exp_first;
        int            exp_last;
        logic [15:0]   exp_xor;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] n, input logic [CW-1:0] s);
        @(negedge clk);
        start    = 1'b1;
        nrounds  = n;
        state_in = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int vcyc = -1, vcnt = 0, first_r = -1, last_r = -1;
        logic [CW-1:0] got = '0;
        logic [CW-1:0] exp_out;
        exp_out = v.sin ^ {20{v.exp_xor}};
        applyStimulus(v.nr, v.sin);
        for (int c = 1; c <= v.exp_cycle + 5; c++) begin
            @(negedge clk);
            if (!core_reset) begin
                if (first_r < 0) first_r = int'(core_round);
                last_r = int'(core_round);
            end
            if (valid) begin
                vcnt++;
                if (vcyc < 0) begin
                    vcyc = c;
                    got  = state_out;
                end
            end
        end
        checkOutput($sformatf("v%0d_valid_cycle", idx), CW'(vcyc), CW'(v.exp_cycle));
        checkOutput($sformatf("v%0d_valid_count", idx), CW'(vcnt), CW'(1));
        checkOutput($sformatf("v%0d_state_out", idx), got, exp_out);
        checkOutput($sformatf("v%0d_first_round", idx), CW'(first_r), CW'(v.exp_first));
        checkOutput($sformatf("v%0d_last_round", idx), CW'(last_r), CW'(v.exp_last));
        checkOutput($sformatf("v%0d_ready_after", idx), CW'(ready), CW'(1));
    endtask

    initial begin
        logic [CW-1:0] p1, p2, p3, p4, p5, pa5;
        int vcnt, vcyc, bad;
        logic [CW-1:0] got;

        p1  = {5{64'h0123_4567_89AB_CDEF}};
        p2  = {5{64'hDEAD_BEEF_CAFE_F00D}};
        p3  = {5{64'h1357_9BDF_2468_ACE0}};
        p4  = {5{64'hFEDC_BA98_7654_3210}};
        p5  = {5{64'h0F1E_2D3C_4B5A_6978}};
        pa5 = {40{8'hA5}};

        // Expected XOR is the XOR of all round indices ridx0..11 applied.
        vecs[0] = '{4'd1,  '0,  5,  11, 11, 16'h000B};
        vecs[1] = '{4'd12, p1,  60, 0,  11, 16'h0000};
        vecs[2] = '{4'd6,  p2,  30, 6,  11, 16'h0001};
        vecs[3] = '{4'd15, p3,  60, 0,  11, 16'h0000};
        vecs[4] = '{4'd0,  pa5, 1,  -1, -1, 16'h0000};
        vecs[5] = '{4'd3,  p4,  15, 9,  11, 16'h0008};
        vecs[6] = '{4'd5,  p5,  25, 7,  11, 16'h0007};
        vecs[7] = '{4'd2,  p1,  10, 10, 11, 16'h0001};

        reset = 1'b1; start = 1'b0; nrounds = '0; state_in = '0;
        stuck = 1'b0; done_force = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", CW'(ready), CW'(1));
        checkOutput("rst_busy", CW'(busy), CW'(0));
        checkOutput("rst_valid", CW'(valid), CW'(0));
        checkOutput("rst_error", CW'(error), CW'(0));
        checkOutput("rst_state_out", state_out, '0);
        checkOutput("rst_core_c", core_c, '0);
        checkOutput("rst_core_round", CW'(core_round), CW'(0));
        checkOutput("rst_core_reset", CW'(core_reset), CW'(1));

        for (int i = 0; i < 8; i++) runVector(vecs[i], i);

        // core_done while idle must not start anything
        done_force = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!ready || valid) bad++;
        end
        done_force = 1'b0;
        checkOutput("idle_done_ignored", CW'(bad), CW'(0));

        // start pulsed mid-run is ignored
        applyStimulus(4'd12, p2);
        vcnt = 0; vcyc = -1; got = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 7) begin
                start = 1'b1; nrounds = 4'd1; state_in = p5;
            end else begin
                start = 1'b0;
            end
            if (valid) begin
                vcnt++;
                if (vcyc < 0) begin vcyc = c; got = state_out; end
            end
        end
        checkOutput("busy_start_valid_cycle", CW'(vcyc), CW'(60));
        checkOutput("busy_start_valid_count", CW'(vcnt), CW'(1));
        checkOutput("busy_start_state_out", got, p2);

        // reset mid-run aborts
        applyStimulus(4'd12, p3);
        vcnt = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (c == 20) reset = 1'b1;
            if (c == 21) begin
                checkOutput("abort_ready", CW'(ready), CW'(1));
                checkOutput("abort_core_reset", CW'(core_reset), CW'(1));
                checkOutput("abort_state_out", state_out, '0);
                reset = 1'b0;
            end
        end
        checkOutput("abort_no_valid", CW'(vcnt), CW'(0));

`ifdef GASCON_SEQ_WATCHDOG_EN
        stuck = 1'b1;
        applyStimulus(4'd1, p4);
        vcnt = 0; vcyc = -1; bad = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (error && vcyc < 0) vcyc = c;
            if (vcyc > 0 && c == vcyc + 1 && !ready) bad++;
        end
        stuck = 1'b0;
        checkOutput("wdt_error_cycle", CW'(vcyc), CW'(1024));
        checkOutput("wdt_no_valid", CW'(vcnt), CW'(0));
        checkOutput("wdt_ready_next", CW'(bad), CW'(0));
        checkOutput("wdt_error_total", CW'(err_total), CW'(1));
`else
        checkOutput("error_never", CW'(err_total), CW'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
